// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions: address width, reset vector,
// instruction size and the address type used across the pipeline.
package pipeline_pkg;

    localparam int ADDR_W      = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t RESET_VECTOR = 32'h0000_0000;

endpackage : pipeline_pkg

// File: rtl/pc_incrementer.sv
// Sequential-successor adder: sum = addr + INC, wrapping modulo 2^WIDTH.
// Shared between the PC register and the branch-target path.
module pc_incrementer #(
    parameter int WIDTH = 32,
    parameter int INC   = 4
) (
    input  logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] sum
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    // Plain WIDTH-bit add; the carry out is dropped so the result wraps.
    always_comb begin
        sum = addr + INC_W;
    end

endmodule : pc_incrementer

// File: rtl/program_counter.sv
// Program-counter register at the head of the fetch stage.
// Loads the upstream next-PC on each enabled edge, holds on stall, and
// offers out + INC to the next-PC mux.
// Optional feature macro: PC_ALIGN_CHECK_EN adds the registered misalign
// flag, which reports whether the loaded PC is not a multiple of INC.
module program_counter
    import pipeline_pkg::*;
#(
    parameter int               WIDTH        = ADDR_W,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(pipeline_pkg::RESET_VECTOR),
    parameter int               INC          = INSTR_BYTES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misalign,
`endif
    output logic [WIDTH-1:0] out_next
);

    // PC register: reset wins over enable; odd values load unmodified.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= RESET_VECTOR;
        end else if (en) begin
            out <= in;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    // Alignment flag tracks the value being loaded so it stays paired with out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (en) begin
            misalign <= ((in % INC_W) != '0);
        end
    end
`endif

    pc_incrementer #(
        .WIDTH (WIDTH),
        .INC   (INC)
    ) u_pc_incrementer (
        .addr (out),
        .sum  (out_next)
    );

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed bench for program_counter; misalign checks are compiled in
// only when PC_ALIGN_CHECK_EN is defined.
module tb_program_counter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] in;
    logic [31:0] out;
    logic [31:0] out_next;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;

    program_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in       (in),
        .out      (out),
`ifdef PC_ALIGN_CHECK_EN
        .misalign (misalign),
`endif
        .out_next (out_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset held for two edges with a nonzero input present.
        rst_n = 1'b0;
        en    = 1'b1;
        in    = 32'h0000_1234;
        tick();
        tick();
        check("rst_out", out, 32'h0000_0000);
        check("rst_out_next", out_next, 32'h0000_0004);
`ifdef PC_ALIGN_CHECK_EN
        check("rst_misalign", {31'd0, misalign}, 32'd0);
`endif

        // 2. First load of an odd address.
        rst_n = 1'b1;
        en    = 1'b1;
        in    = 32'h0000_0001;
        tick();
        check("load1_out", out, 32'h0000_0001);
        check("load1_out_next", out_next, 32'h0000_0005);
`ifdef PC_ALIGN_CHECK_EN
        check("load1_misalign", {31'd0, misalign}, 32'd1);
`endif

        // 3. Back-to-back load of 111111 decimal.
        in = 32'h0001_B207;
        tick();
        check("load2_out", out, 32'h0001_B207);
        check("load2_out_next", out_next, 32'h0001_B20B);
`ifdef PC_ALIGN_CHECK_EN
        check("load2_misalign", {31'd0, misalign}, 32'd1);
`endif

        // 4. Stall for three edges, then release.
        en = 1'b0;
        in = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_out", out, 32'h0001_B207);
`ifdef PC_ALIGN_CHECK_EN
            check("stall_misalign", {31'd0, misalign}, 32'd1);
`endif
        end
        en = 1'b1;
        tick();
        check("release_out", out, 32'h0000_0040);
        check("release_out_next", out_next, 32'h0000_0044);
`ifdef PC_ALIGN_CHECK_EN
        check("release_misalign", {31'd0, misalign}, 32'd0);
`endif

        // 5. Wrap of out_next at the top of the address space.
        in = 32'hFFFF_FFFC;
        tick();
        check("wrap_out", out, 32'hFFFF_FFFC);
        check("wrap_out_next", out_next, 32'h0000_0000);
`ifdef PC_ALIGN_CHECK_EN
        check("wrap_misalign", {31'd0, misalign}, 32'd0);
`endif

        // Misaligned load, then a mid-stream reset that overrides en=1.
        in = 32'h0000_0003;
        tick();
        check("odd_out", out, 32'h0000_0003);
        check("odd_out_next", out_next, 32'h0000_0007);
`ifdef PC_ALIGN_CHECK_EN
        check("odd_misalign", {31'd0, misalign}, 32'd1);
`endif
        rst_n = 1'b0;
        en    = 1'b1;
        in    = 32'h0000_0008;
        tick();
        check("midrst_out", out, 32'h0000_0000);
        check("midrst_out_next", out_next, 32'h0000_0004);
`ifdef PC_ALIGN_CHECK_EN
        check("midrst_misalign", {31'd0, misalign}, 32'd0);
`endif

        // 6. Input changes between edges do not reach out.
        rst_n = 1'b1;
        in    = 32'h0000_0100;
        tick();
        check("pre_glitch_out", out, 32'h0000_0100);
        #1;
        in = 32'h0000_0202;
        #1;
        check("glitch_out", out, 32'h0000_0100);
        check("glitch_out_next", out_next, 32'h0000_0104);
        tick();
        check("post_glitch_out", out, 32'h0000_0202);
`ifdef PC_ALIGN_CHECK_EN
        check("post_glitch_misalign", {31'd0, misalign}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_program_counter
